// File: rtl/aes128_round_seq.sv
// AES-128 round sequencer: issues the fixed op stream for a key schedule,
// an encryption or a decryption to the vector AES datapath, one op per
// valid/ready transfer, and tracks whether a complete key schedule is held.
//
// Handshake: op_valid is high for the whole ISSUE state. A transfer happens
// on a rising clock edge where op_valid & op_ready are both high. op, rk_idx
// and rcon depend only on registered state, so they hold steady while the
// datapath stalls (op_ready low). op_valid never drops inside a job except
// on abort or reset.
module aes128_round_seq #(
   parameter int unsigned NR = 10   // rounds, 1..10
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic       abort,
   input  logic       op_ready,
   output logic       op_valid,
   output logic [2:0] op,
   output logic [3:0] rk_idx,
   output logic [7:0] rcon,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       key_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   localparam logic [2:0] OP_KS_STORE = 3'd0;
   localparam logic [2:0] OP_KS_STEP  = 3'd1;
   localparam logic [2:0] OP_ARK      = 3'd2;
   localparam logic [2:0] OP_SSM      = 3'd3;
   localparam logic [2:0] OP_SS       = 3'd4;
   localparam logic [2:0] OP_ISSM     = 3'd5;
   localparam logic [2:0] OP_ISS      = 3'd6;
   localparam logic [2:0] OP_IMC_ARK  = 3'd7;

   localparam logic [1:0] MODE_KS  = 2'b00;
   localparam logic [1:0] MODE_ENC = 2'b01;
   localparam logic [1:0] MODE_DEC = 2'b10;

   localparam logic [4:0] LAST_STEP = 5'(2 * NR);
   localparam logic [4:0] SUB_STEP  = 5'(2 * NR - 1);   // final SubBytes/ShiftRows
   localparam logic [3:0] NR_IDX    = 4'(NR);

   state_t     state_q, state_d;
   logic [4:0] step_q, step_d;
   logic [1:0] mode_q, mode_d;
   logic       key_valid_q, key_valid_d;
   logic       err_q, err_d;

   logic       xfer;
   logic       start_ok;

   // AES key-expansion round constants, indexed by key-schedule round.
   function automatic logic [7:0] rc_of(input logic [3:0] i);
      case (i)
         4'd0:    rc_of = 8'h01;
         4'd1:    rc_of = 8'h02;
         4'd2:    rc_of = 8'h04;
         4'd3:    rc_of = 8'h08;
         4'd4:    rc_of = 8'h10;
         4'd5:    rc_of = 8'h20;
         4'd6:    rc_of = 8'h40;
         4'd7:    rc_of = 8'h80;
         4'd8:    rc_of = 8'h1B;
         4'd9:    rc_of = 8'h36;
         default: rc_of = 8'h00;
      endcase
   endfunction

   assign xfer = (state_q == S_ISSUE) && op_ready;

   // Encrypt/decrypt need a finished key schedule; mode 11 is never legal.
   assign start_ok = (mode == MODE_KS) ||
                     (((mode == MODE_ENC) || (mode == MODE_DEC)) && key_valid_q);

   // State and job registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= S_IDLE;
         step_q      <= 5'd0;
         mode_q      <= 2'b00;
         key_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         mode_q      <= mode_d;
         key_valid_q <= key_valid_d;
         err_q       <= err_d;
      end
   end

   // Next state: abort wins over any further issue, including the last step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && start_ok) state_d = S_ISSUE;
         S_ISSUE: begin
            if (abort)                             state_d = S_IDLE;
            else if (xfer && step_q == LAST_STEP)  state_d = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next step counter, latched mode, key-valid flag and reject pulse.
   always_comb begin
      step_d      = step_q;
      mode_d      = mode_q;
      key_valid_d = key_valid_q;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            step_d = 5'd0;
            if (start && start_ok) begin
               mode_d = mode;
               // A new key schedule invalidates the old one immediately.
               if (mode == MODE_KS) key_valid_d = 1'b0;
            end
            if (start && !start_ok) err_d = 1'b1;
         end
         S_ISSUE: begin
            if (abort) begin
               step_d = 5'd0;
            end else if (xfer) begin
               if (step_q == LAST_STEP) begin
                  step_d = 5'd0;
                  if (mode_q == MODE_KS) key_valid_d = 1'b1;
               end else begin
                  step_d = step_q + 5'd1;
               end
            end
         end
         default: step_d = 5'd0;
      endcase
   end

   // Outputs and op decode from the registered step and latched mode.
   always_comb begin
      op_valid  = (state_q == S_ISSUE);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_FIN);
      err       = err_q;
      key_valid = key_valid_q;
      op        = 3'd0;
      rk_idx    = 4'd0;
      rcon      = 8'd0;
      if (state_q == S_ISSUE) begin
         case (mode_q)
            MODE_KS: begin
               if (step_q[0]) begin
                  op   = OP_KS_STEP;
                  rcon = rc_of(step_q[4:1]);
               end else begin
                  op     = OP_KS_STORE;
                  rk_idx = step_q[4:1];
               end
            end
            MODE_ENC: begin
               if (step_q == 5'd0) begin
                  op = OP_ARK;
               end else if (step_q == LAST_STEP) begin
                  op     = OP_ARK;
                  rk_idx = NR_IDX;
               end else if (step_q == SUB_STEP) begin
                  op = OP_SS;
               end else if (step_q[0]) begin
                  op = OP_SSM;
               end else begin
                  op     = OP_ARK;
                  rk_idx = step_q[4:1];
               end
            end
            MODE_DEC: begin
               if (step_q == 5'd0) begin
                  op     = OP_ARK;
                  rk_idx = NR_IDX;
               end else if (step_q == LAST_STEP) begin
                  op = OP_ARK;
               end else if (step_q == SUB_STEP) begin
                  op = OP_ISS;
               end else if (step_q[0]) begin
                  op = OP_ISSM;
               end else begin
                  op     = OP_IMC_ARK;
                  rk_idx = NR_IDX - step_q[4:1];
               end
            end
            default: op = 3'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_round_seq.sv
// Bench for aes128_round_seq: expected ops are queued when a job is started
// and a negedge monitor compares/pops them as the sequencer issues them.
module tb_aes128_round_seq;

   localparam int NR = 10;

   logic       clk = 1'b0;
   logic       clrn;
   logic       start;
   logic [1:0] mode;
   logic       abort;
   logic       op_ready;
   logic       op_valid;
   logic [2:0] op;
   logic [3:0] rk_idx;
   logic [7:0] rcon;
   logic       busy;
   logic       done;
   logic       err;
   logic       key_valid;

   logic [14:0] exp_q[$];   // {op, rk_idx, rcon}
   int n_checks = 0;
   int n_fail   = 0;
   int n_hs     = 0;

   logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   aes128_round_seq #(.NR(NR)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .start     (start),
      .mode      (mode),
      .abort     (abort),
      .op_ready  (op_ready),
      .op_valid  (op_valid),
      .op        (op),
      .rk_idx    (rk_idx),
      .rcon      (rcon),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .key_valid (key_valid)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required earlier finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference op table ----------------
   function automatic logic [14:0] model(input logic [1:0] m, input int s);
      logic [2:0] o;
      logic [3:0] k;
      logic [7:0] r;
      o = 3'd0; k = 4'd0; r = 8'd0;
      case (m)
         2'b00: begin
            if (s % 2 == 0) begin o = 3'd0; k = 4'(s / 2); end
            else            begin o = 3'd1; r = rc_tab[(s - 1) / 2]; end
         end
         2'b01: begin
            if (s == 0)               o = 3'd2;
            else if (s == 2*NR)       begin o = 3'd2; k = 4'(NR); end
            else if (s == 2*NR - 1)   o = 3'd4;
            else if (s % 2 == 1)      o = 3'd3;
            else                      begin o = 3'd2; k = 4'(s / 2); end
         end
         2'b10: begin
            if (s == 0)               begin o = 3'd2; k = 4'(NR); end
            else if (s == 2*NR)       o = 3'd2;
            else if (s == 2*NR - 1)   o = 3'd6;
            else if (s % 2 == 1)      o = 3'd5;
            else                      begin o = 3'd7; k = 4'(NR - s / 2); end
         end
         default: o = 3'd0;
      endcase
      return {o, k, r};
   endfunction

   // ---------------- scoreboard monitor ----------------
   // Every cycle with op_valid the presented op must equal the queue head;
   // it is popped only when the transfer happens, so stalls re-check it.
   always @(negedge clk) begin
      if (clrn === 1'b1 && op_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL op_stream: op=%0d rk=%0d rcon=%h issued, required no op (queue empty)",
                     op, rk_idx, rcon);
         end else begin
            if ({op, rk_idx, rcon} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL op_stream: got op=%0d rk=%0d rcon=%h, required op=%0d rk=%0d rcon=%h",
                        op, rk_idx, rcon, exp_q[0][14:12], exp_q[0][11:8], exp_q[0][7:0]);
            end
            if (op_ready === 1'b1) begin
               void'(exp_q.pop_front());
               n_hs++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_job(input logic [1:0] m);
      for (int s = 0; s <= 2*NR; s++) exp_q.push_back(model(m, s));
   endtask

   // Returns #1 into the cycle after start was sampled (cycle 1 of a job).
   task automatic pulse_start(input logic [1:0] m);
      @(posedge clk); #1;
      start = 1'b1;
      mode  = m;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      clrn = 1'b0; start = 1'b0; mode = 2'b00; abort = 1'b0; op_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({op_valid, op, rk_idx, rcon, busy, done, err, key_valid} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 00000",
                  {op_valid, op, rk_idx, rcon, busy, done, err, key_valid});
      end
      @(posedge clk); #1;
      clrn = 1'b1;
   endtask

   task automatic test_reject(input logic [1:0] m);
      pulse_start(m);
      @(negedge clk);
      n_checks++;
      if ({err, op_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL reject_m%0d: err/op_valid/busy=%b, required 100", m, {err, op_valid, busy});
      end
      @(negedge clk);
      n_checks++;
      if ({err, op_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL reject_pulse_m%0d: err/op_valid=%b, required 00", m, {err, op_valid});
      end
   endtask

   task automatic test_key_schedule;
      int cyc;
      int hs0;
      hs0 = n_hs;
      op_ready = 1'b1;
      push_job(2'b00);
      pulse_start(2'b00);
      @(negedge clk);
      n_checks++;
      if ({busy, op_valid, key_valid} !== 3'b110) begin
         n_fail++;
         $display("FAIL ks_begin: busy/op_valid/key_valid=%b, required 110", {busy, op_valid, key_valid});
      end
      cyc = 1;
      while (done !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 22) begin
         n_fail++;
         $display("FAIL ks_done_cycle: done seen at cycle %0d, required 22", cyc);
      end
      n_checks++;
      if ((n_hs - hs0) != 21 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL ks_op_count: transfers=%0d left=%0d, required 21 and 0", n_hs - hs0, exp_q.size());
      end
      @(negedge clk);
      n_checks++;
      if ({key_valid, done, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL ks_after: key_valid/done/busy=%b, required 100", {key_valid, done, busy});
      end
   endtask

   task automatic test_encrypt;
      int cyc;
      int hs0;
      int n_err;
      hs0 = n_hs; n_err = 0;
      op_ready = 1'b1;
      push_job(2'b01);
      pulse_start(2'b01);
      cyc = 1;
      while (done !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1;
         // Start outside IDLE and a mode change must both be ignored.
         start = (cyc == 4);
         if (cyc == 4) mode = 2'b11;
         if (cyc == 5) mode = 2'b10;
         @(negedge clk);
         cyc++;
         if (err === 1'b1) n_err++;
      end
      start = 1'b0;
      n_checks++;
      if (cyc != 22) begin
         n_fail++;
         $display("FAIL enc_done_cycle: done seen at cycle %0d, required 22", cyc);
      end
      n_checks++;
      if (n_err != 0) begin
         n_fail++;
         $display("FAIL enc_busy_start: err pulses=%0d, required 0", n_err);
      end
      n_checks++;
      if ((n_hs - hs0) != 21 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL enc_op_count: transfers=%0d left=%0d, required 21 and 0", n_hs - hs0, exp_q.size());
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done, key_valid} !== 3'b001) begin
         n_fail++;
         $display("FAIL enc_after: busy/done/key_valid=%b, required 001", {busy, done, key_valid});
      end
   endtask

   task automatic test_decrypt_stall;
      int cyc;
      int hs0;
      int stalls;
      int n_done;
      hs0 = n_hs; stalls = 0; n_done = 0;
      op_ready = 1'b1;
      push_job(2'b10);
      pulse_start(2'b10);
      cyc = 1;
      while (cyc < 200) begin
         @(negedge clk);
         if (op_valid === 1'b1 && op_ready === 1'b0) stalls++;
         if (done === 1'b1) n_done++;
         if (done === 1'b1) break;
         @(posedge clk); #1;
         op_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         cyc++;
      end
      op_ready = 1'b1;
      n_checks++;
      if (n_done != 1) begin
         n_fail++;
         $display("FAIL dec_done: done pulses=%0d within budget, required 1", n_done);
      end
      n_checks++;
      if ((n_hs - hs0) != 21 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL dec_op_count: transfers=%0d left=%0d, required 21 and 0", n_hs - hs0, exp_q.size());
      end
      n_checks++;
      if (stalls < 10) begin
         n_fail++;
         $display("FAIL dec_stalls: stall cycles=%0d, required at least 10", stalls);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done, key_valid} !== 3'b001) begin
         n_fail++;
         $display("FAIL dec_after: busy/done/key_valid=%b, required 001", {busy, done, key_valid});
      end
   endtask

   task automatic test_abort;
      int hs0;
      int n_done;
      hs0 = n_hs; n_done = 0;
      op_ready = 1'b1;
      push_job(2'b00);
      pulse_start(2'b00);
      repeat (7) @(posedge clk);
      #1 abort = 1'b1;            // step 7 is on the bus this cycle
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({op_valid, busy, done, key_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL abort_state: op_valid/busy/done/key_valid=%b, required 0000",
                  {op_valid, busy, done, key_valid});
      end
      n_checks++;
      if ((n_hs - hs0) != 8) begin
         n_fail++;
         $display("FAIL abort_consumed: transfers=%0d, required 8", n_hs - hs0);
      end
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_checks++;
      if (n_done != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: done pulses=%0d, required 0", n_done);
      end
      test_key_schedule();
   endtask

   task automatic test_reset_mid_job;
      op_ready = 1'b1;
      push_job(2'b01);
      pulse_start(2'b01);
      repeat (10) @(posedge clk);
      #2 clrn = 1'b0;             // step 10 is on the bus
      #1;
      n_checks++;
      if ({op_valid, op, rk_idx, rcon, busy, done, err, key_valid} !== 20'd0) begin
         n_fail++;
         $display("FAIL async_reset: outputs=%h, required 00000",
                  {op_valid, op, rk_idx, rcon, busy, done, err, key_valid});
      end
      exp_q.delete();
      @(posedge clk); #1;
      clrn = 1'b1;
      test_reject(2'b01);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_reject(2'b01);
      test_reject(2'b11);
      test_key_schedule();
      test_encrypt();
      test_decrypt_stall();
      test_abort();
      test_reset_mid_job();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
